// File: rtl/multi_key_tone_gen.sv
// Multi-key square-wave tone generator: per-key sync/debounce, hold/latch selection,
// glitch-free half-period switching, active flag and thermometer LED output.

module mktg_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic db,
  output logic db_nxt
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);

  logic          s1, s2;
  logic [DW-1:0] cnt;
  logic          settle;

  assign settle = (s2 != db) && (cnt == DW'(DEBOUNCE_CYCLES - 1));
  assign db_nxt = settle ? s2 : db;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1  <= 1'b1;
      s2  <= 1'b1;
      db  <= 1'b1;
      cnt <= '0;
    end else begin
      s1 <= key_raw;
      s2 <= s1;
      db <= db_nxt;
      if (s2 == db || settle) cnt <= '0;
      else                    cnt <= cnt + DW'(1);
    end
  end
endmodule

module multi_key_tone_gen #(
  parameter int NUM_KEYS        = 5,
  parameter int CNT_W           = 32,
  parameter int BASE_HALF       = 100000,
  parameter int STEP_HALF       = 100000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key,
  input  logic                mode,
  output logic                beep,
  output logic [NUM_KEYS-1:0] led,
  output logic                active
);
  localparam int SW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

  logic [NUM_KEYS-1:0] db, db_nxt, press, led_n;
  logic [CNT_W-1:0]    half_tbl [NUM_KEYS];
  logic [CNT_W-1:0]    hc, cur_half;
  logic [SW-1:0]       hold_sel, press_sel, lat_sel, lat_sel_n, sel_n;
  logic                hold_any, mode_q, mode_chg, lat_act, lat_act_n, act_n;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    mktg_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .key_raw(key[g]),
      .db     (db[g]),
      .db_nxt (db_nxt[g])
    );
    assign half_tbl[g] = CNT_W'(longint'(BASE_HALF) + longint'(g) * longint'(STEP_HALF));
  end

  // Selection is resolved from the next debounced value so active/led move with the debounce edge
  always_comb begin
    press     = db & ~db_nxt;
    hold_any  = ~&db_nxt;
    hold_sel  = '0;
    press_sel = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (!db_nxt[i]) hold_sel  = SW'(i);
      if (press[i])   press_sel = SW'(i);
    end
    mode_chg  = mode ^ mode_q;
    lat_act_n = lat_act;
    lat_sel_n = lat_sel;
    if (mode_chg || !mode) begin
      lat_act_n = 1'b0;
    end else if (|press) begin
      if (lat_act && lat_sel == press_sel) begin
        lat_act_n = 1'b0;
      end else begin
        lat_act_n = 1'b1;
        lat_sel_n = press_sel;
      end
    end
    act_n = !mode_chg && (mode ? lat_act_n : hold_any);
    sel_n = mode ? lat_sel_n : hold_sel;
    led_n = '0;
    for (int j = 0; j < NUM_KEYS; j++) led_n[j] = act_n && (j <= int'(sel_n));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q   <= 1'b0;
      lat_act  <= 1'b0;
      lat_sel  <= '0;
      active   <= 1'b0;
      led      <= '0;
      beep     <= 1'b0;
      hc       <= '0;
      cur_half <= '0;
    end else begin
      mode_q  <= mode;
      lat_act <= lat_act_n;
      lat_sel <= lat_sel_n;
      active  <= act_n;
      led     <= led_n;
      // Half-period only reloads at a toggle, so a new selection never cuts a half short
      if (!act_n) begin
        beep <= 1'b0;
        hc   <= '0;
      end else if (!active) begin
        beep     <= 1'b0;
        hc       <= '0;
        cur_half <= half_tbl[sel_n];
      end else if (hc == cur_half - CNT_W'(1)) begin
        beep     <= ~beep;
        hc       <= '0;
        cur_half <= half_tbl[sel_n];
      end else begin
        hc <= hc + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_multi_key_tone_gen.sv
// Bench for multi_key_tone_gen: directed scenarios plus random keys/mode/reset vs a
// cycle reference model built on run-lengths and a half-period countdown.

module tb_multi_key_tone_gen;
  localparam int NK   = 5;
  localparam int DEB  = 4;
  localparam int BASE = 10;
  localparam int STEP = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mode = 1'b0;
  logic [NK-1:0] key = '1;
  logic          beep, active;
  logic [NK-1:0] led;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  multi_key_tone_gen #(
    .NUM_KEYS(NK), .CNT_W(16), .BASE_HALF(BASE), .STEP_HALF(STEP), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key(key), .mode(mode),
    .beep(beep), .led(led), .active(active)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [NK-1:0] m_s1, m_s2, m_db, m_last, m_led;
  int            m_run [NK];
  logic          m_mprev, m_lact, m_active, m_beep;
  int            m_lsel, m_rem;

  task automatic model_step();
    logic [NK-1:0] samp, dbn, press;
    int hsel, psel, sel;
    bit hany, chg, act;
    if (!rst_n) begin
      m_s1 = '1; m_s2 = '1; m_db = '1; m_last = '1;
      for (int i = 0; i < NK; i++) m_run[i] = 0;
      m_mprev = 1'b0; m_lact = 1'b0; m_lsel = 0;
      m_active = 1'b0; m_led = '0; m_beep = 1'b0; m_rem = 0;
      return;
    end
    samp = m_s2; m_s2 = m_s1; m_s1 = key;
    dbn = m_db;
    for (int i = 0; i < NK; i++) begin
      if (samp[i] == m_last[i]) m_run[i]++;
      else begin m_run[i] = 1; m_last[i] = samp[i]; end
      if (samp[i] != m_db[i] && m_run[i] >= DEB) dbn[i] = samp[i];
    end
    press = m_db & ~dbn;
    hany = 0; hsel = 0; psel = 0;
    for (int i = NK - 1; i >= 0; i--) begin
      if (!dbn[i]) begin hany = 1; hsel = i; end
      if (press[i]) psel = i;
    end
    chg = (mode != m_mprev);
    m_mprev = mode;
    if (chg || !mode) m_lact = 1'b0;
    else if (press != '0) begin
      if (m_lact && m_lsel == psel) m_lact = 1'b0;
      else begin m_lact = 1'b1; m_lsel = psel; end
    end
    act = !chg && (mode ? m_lact : hany);
    sel = mode ? m_lsel : hsel;
    if (!act) begin
      m_beep = 1'b0; m_rem = 0;
    end else if (!m_active) begin
      m_beep = 1'b0; m_rem = BASE + sel * STEP;
    end else if (m_rem == 1) begin
      m_beep = ~m_beep; m_rem = BASE + sel * STEP;
    end else begin
      m_rem--;
    end
    m_led = act ? NK'((1 << (sel + 1)) - 1) : '0;
    m_active = act;
    m_db = dbn;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; key = '1; mode = 1'b0;
    tick(); tick();
    checks++; if (beep !== 1'b0) begin failures++; $display("FAIL reset_beep got=%b exp=0", beep); end
    checks++; if (led !== 5'b00000) begin failures++; $display("FAIL reset_led got=%b exp=00000", led); end
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL reset_active got=%b exp=0", active); end
    rst_n = 1'b1;
    tick();
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL post_reset_active got=%b exp=0", active); end
  endtask

  task automatic test_hold_single();
    key = 5'b11110;
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++; if (active !== (k == 6)) begin failures++; $display("FAIL hold_active k=%0d got=%b exp=%b", k, active, k == 6); end
      checks++; if (led !== ((k == 6) ? 5'b00001 : 5'b00000)) begin failures++; $display("FAIL hold_led k=%0d got=%b", k, led); end
    end
    for (int k = 1; k <= 25; k++) begin
      tick();
      checks++; if (beep !== (k >= 10 && k < 20)) begin failures++; $display("FAIL hold_beep k=%0d got=%b exp=%b", k, beep, (k >= 10 && k < 20)); end
      checks++; if (beep !== m_beep) begin failures++; $display("FAIL hold_beep_model k=%0d got=%b exp=%b", k, beep, m_beep); end
    end
  endtask

  task automatic test_hold_switch();
    logic prev;
    int n;
    key = 5'b11010;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++; if (led !== 5'b00001) begin failures++; $display("FAIL two_led k=%0d got=%b exp=00001", k, led); end
      checks++; if (beep !== m_beep) begin failures++; $display("FAIL two_beep k=%0d got=%b exp=%b", k, beep, m_beep); end
    end
    key = 5'b11011;
    for (int k = 1; k <= 40; k++) begin
      tick();
      checks++; if (led !== ((k >= 6) ? 5'b00111 : 5'b00001)) begin failures++; $display("FAIL switch_led k=%0d got=%b", k, led); end
      checks++; if (beep !== m_beep) begin failures++; $display("FAIL switch_beep k=%0d got=%b exp=%b", k, beep, m_beep); end
    end
    prev = beep; n = 0;
    while (beep === prev && n < 40) begin tick(); n++; end
    checks++; if (n >= 40) begin failures++; $display("FAIL switch_edge_timeout got=%0d exp<40", n); end
    prev = beep; n = 0;
    while (beep === prev && n < 40) begin tick(); n++; end
    checks++; if (n != 30) begin failures++; $display("FAIL switch_half got=%0d exp=30", n); end
  endtask

  task automatic test_bounce();
    key = '1;
    for (int k = 0; k < 12; k++) tick();
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL release_active got=%b exp=0", active); end
    for (int k = 0; k < 15; k++) begin
      key = (k < 3) ? 5'b10111 : 5'b11111;
      tick();
      checks++; if ({active, beep, led} !== 7'd0) begin failures++; $display("FAIL bounce k=%0d got=%b%b%b exp=0", k, active, beep, led); end
    end
  endtask

  task automatic test_latch();
    logic prev;
    int n;
    mode = 1'b1;
    tick(); tick();
    key = 5'b01111;
    for (int k = 0; k < 8; k++) tick();
    key = '1;
    for (int k = 0; k < 8; k++) tick();
    checks++; if (active !== 1'b1) begin failures++; $display("FAIL latch_active got=%b exp=1", active); end
    checks++; if (led !== 5'b11111) begin failures++; $display("FAIL latch_led got=%b exp=11111", led); end
    prev = beep; n = 0;
    while (beep === prev && n < 60) begin tick(); n++; end
    checks++; if (n >= 60) begin failures++; $display("FAIL latch_edge_timeout got=%0d exp<60", n); end
    prev = beep; n = 0;
    while (beep === prev && n < 60) begin tick(); n++; end
    checks++; if (n != 50) begin failures++; $display("FAIL latch_half got=%0d exp=50", n); end
    key = 5'b01111; n = 0;
    while (active === 1'b1 && n < 20) begin tick(); n++; end
    checks++; if (n != 6) begin failures++; $display("FAIL unlatch_latency got=%0d exp=6", n); end
    checks++; if (beep !== 1'b0) begin failures++; $display("FAIL unlatch_beep got=%b exp=0", beep); end
    checks++; if (led !== 5'b00000) begin failures++; $display("FAIL unlatch_led got=%b exp=00000", led); end
    key = '1;
    for (int k = 0; k < 10; k++) tick();
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL unlatch_release got=%b exp=0", active); end
  endtask

  task automatic test_mode_flip();
    key = 5'b11101;
    for (int k = 0; k < 8; k++) tick();
    key = '1;
    for (int k = 0; k < 8; k++) tick();
    checks++; if (led !== 5'b00011) begin failures++; $display("FAIL flip_pre_led got=%b exp=00011", led); end
    mode = 1'b0;
    tick();
    checks++; if ({active, beep, led} !== 7'd0) begin failures++; $display("FAIL flip_clear got=%b%b%b exp=0", active, beep, led); end
    for (int k = 0; k < 4; k++) tick();
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL flip_stay got=%b exp=0", active); end
  endtask

  task automatic test_reset_mid();
    int n;
    key = 5'b11110; n = 0;
    while (beep !== 1'b1 && n < 30) begin tick(); n++; end
    checks++; if (n >= 30) begin failures++; $display("FAIL rstmid_beep_timeout got=%0d exp<30", n); end
    rst_n = 1'b0;
    tick();
    checks++; if ({active, beep, led} !== 7'd0) begin failures++; $display("FAIL rstmid_clear got=%b%b%b exp=0", active, beep, led); end
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++; if (active !== (k == 6)) begin failures++; $display("FAIL rstmid_requal k=%0d got=%b exp=%b", k, active, k == 6); end
    end
  endtask

  task automatic test_random();
    logic [NK-1:0] t;
    int r, len, start;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    start = cyc;
    while (cyc - start < 1500) begin
      r = $urandom_range(0, 99);
      if (r < 3) rst_n = 1'b0;
      else if (r < 10) mode = ~mode;
      case ($urandom_range(0, 3))
        0: t = '1;
        1: begin t = '1; t[$urandom_range(0, NK - 1)] = 1'b0; end
        2: begin t = '1; t[$urandom_range(0, NK - 1)] = 1'b0; t[$urandom_range(0, NK - 1)] = 1'b0; end
        default: t = NK'($urandom);
      endcase
      key = t;
      len = $urandom_range(1, 14);
      for (int k = 0; k < len; k++) begin
        tick();
        rst_n = 1'b1;
        checks++; if (beep !== m_beep) begin failures++; $display("FAIL rand_beep cyc=%0d got=%b exp=%b", cyc, beep, m_beep); end
        checks++; if (led !== m_led) begin failures++; $display("FAIL rand_led cyc=%0d got=%b exp=%b", cyc, led, m_led); end
        checks++; if (active !== m_active) begin failures++; $display("FAIL rand_active cyc=%0d got=%b exp=%b", cyc, active, m_active); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_hold_single();
    test_hold_switch();
    test_bounce();
    test_latch();
    test_mode_flip();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
